// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Loader state encoding, frame header byte and word-size helper.
// No timing or flow control; pure declarations.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    function automatic int BYTES_PER_WORD(input int instrs_width);
        return instrs_width / 8;
    endfunction

endpackage

// File: rtl/prog_word_assembler.sv
// Packs MSB-first bytes into instruction words.
// Latency: word_vld/word_dat one cycle after the last byte of a word is accepted.
// Backpressure: none; accepts a byte every cycle byte_vld is high.
module prog_word_assembler
    import prog_loader_pkg::*;
#(
    parameter int INSTRS_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    byte_vld,
    input  logic [7:0]              byte_dat,
    output logic                    last_byte,
    output logic                    word_vld,
    output logic [INSTRS_WIDTH-1:0] word_dat
);

    localparam int BPW = BYTES_PER_WORD(INSTRS_WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [INSTRS_WIDTH-1:0] shift_q, shift_d;
    logic [INSTRS_WIDTH-1:0] word_q, word_d;
    logic [INSTRS_WIDTH-1:0] shift_next;
    logic                    vld_q, vld_d;

    always_comb begin
        shift_next = (shift_q << 8) | INSTRS_WIDTH'(byte_dat);
        last_byte  = byte_vld && (cnt_q == CW'(BPW - 1));
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        vld_d      = 1'b0;
        if (clr) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_vld) begin
            shift_d = shift_next;
            if (last_byte) begin
                cnt_d  = '0;
                word_d = shift_next;
                vld_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
        end
    end

    assign word_vld = vld_q;
    assign word_dat = word_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing instruction words into program RAM; optional checksum via PROG_LOADER_CHECKSUM_EN.
// Latency: wr_en one cycle after the last byte of each word; DONE/ERR one cycle after the final byte.
// Backpressure: byte_ready is high in every state once out of reset; one byte per cycle sustained.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTRS_WIDTH = 32,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    byte_ready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [INSTRS_WIDTH-1:0] wr_data,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    load_error,
    output logic [ADDR_WIDTH:0]     word_count
);

    localparam int         CW      = ADDR_WIDTH + 1;
    localparam logic [8:0] MAX_LEN = 9'(1 << ADDR_WIDTH);

    state_e                  state_q, state_d;
    logic [CW-1:0]           n_q, n_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    byte_ready_q;
    logic                    byte_acc;
    logic                    hdr_acc;
    logic                    asm_vld;
    logic                    asm_last;
    logic                    last_word;
    logic                    word_vld;
    logic [INSTRS_WIDTH-1:0] word_dat;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    assign byte_acc = byte_valid && byte_ready_q;
    assign hdr_acc  = byte_acc && (byte_data == HEADER_BYTE) &&
                      (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign asm_vld  = byte_acc && (state_q == ST_DATA);

    // A write strobe still in flight (one-byte words) counts as already written.
    assign last_word = (count_q + CW'(word_vld)) == (n_q - CW'(1));

    prog_word_assembler #(
        .INSTRS_WIDTH(INSTRS_WIDTH)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (hdr_acc),
        .byte_vld (asm_vld),
        .byte_dat (byte_data),
        .last_byte(asm_last),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        count_d = count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (word_vld) begin
            count_d = count_q + CW'(1);
            // Hold the address on the final word so it never wraps.
            if (count_q + CW'(1) != n_q) begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (hdr_acc) begin
                    state_d = ST_LEN;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN: begin
                if (byte_acc) begin
                    if (byte_data == 8'd0 || {1'b0, byte_data} > MAX_LEN) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = CW'(byte_data);
                        addr_d  = '0;
                        count_d = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (asm_vld) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
                    if (asm_last && last_word) state_d = ST_CSUM;
`else
                    if (asm_last && last_word) state_d = ST_DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (byte_acc) begin
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            byte_ready_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            byte_ready_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = word_vld;
    assign wr_addr    = addr_q;
    assign wr_data    = word_dat;
    assign cpu_hold   = (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign load_error = (state_q == ST_ERR);
    assign word_count = count_q;

endmodule
